serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is 2 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 The block SHALL have port A, input, WIDTH bits: operand A.
REQ-006 The block SHALL have port B, input, WIDTH bits: operand B.
REQ-007 The block SHALL have port CI, input, 1 bit: carry-in for add mode.
REQ-008 The block SHALL have port SUB, input, 1 bit: 1 = A-B, 0 = A+B+CI.
REQ-009 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port S, output, WIDTH bits: result.
REQ-012 The block SHALL have port CO, output, 1 bit: final carry-out.
REQ-013 The block SHALL have port OVF, output, 1 bit: signed overflow.

Function
REQ-014 The block SHALL compute the result bit-serially, LSB first, through exactly one 1-bit full-adder datapath (sum = a^b^c, carry = a&b | (a^b)&c), with carry held in a 1-bit register between bits.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 IDLE SHALL transition to RUN when start=1; otherwise IDLE is held.
REQ-017 RUN SHALL transition to DONE after WIDTH bit cycles; DONE SHALL always transition to IDLE on the next cycle.
REQ-018 Start acceptance SHALL capture A, B (inverted when SUB=1) and SUB into internal registers on that edge, set the carry register to CI when SUB=0 or 1 when SUB=1, and clear the bit counter to 0.
REQ-019 In RUN, each edge SHALL write the full-adder sum for bit index i into S-shadow bit i, update the carry register, and increment i; i SHALL run 0..WIDTH-1 with no wrap.
REQ-020 The block SHALL record the carry into bit WIDTH-1; OVF SHALL equal that carry XOR the final carry.
REQ-021 Timing: with start accepted at edge k, busy SHALL be 1 for edges k+1..k+WIDTH, and done, S, CO and OVF SHALL become valid after edge k+WIDTH, giving a latency of WIDTH+1 cycles.
REQ-022 done SHALL be high only in DONE, for exactly one cycle; busy SHALL be 0 in DONE and IDLE.
REQ-023 S, CO and OVF SHALL update only on the transition into DONE and hold until the next completed operation.
REQ-024 Changes on A, B, CI and SUB after acceptance SHALL not affect the result in flight.
REQ-025 start SHALL be ignored in RUN and DONE; it is not queued. A start held high through DONE SHALL be accepted in the following IDLE cycle.
REQ-026 Sustained back-to-back throughput SHALL be one operation per WIDTH+2 cycles.

Reset
REQ-027 rst=1 at any edge SHALL force IDLE and clear busy, done, S, CO, OVF, the carry register, the counter and the operand registers to 0, including mid-RUN; the aborted result is discarded.
REQ-028 rst SHALL take priority over start on the same edge.

Verification (WIDTH=8)
REQ-029 Scenario: A=0x5A, B=0x33, CI=0, SUB=0, start at edge k -> done at k+8 only, S=0x8D, CO=0, OVF=1; busy high exactly 8 cycles.
REQ-030 Scenario: A=0xFF, B=0x01, CI=0, SUB=0 -> S=0x00, CO=1, OVF=0; also A=0x00, B=0x00, CI=1 -> S=0x01, CO=0.
REQ-031 Scenario: A=0x10, B=0x20, SUB=1, CI=1 (ignored) -> S=0xF0, CO=0, OVF=0; A=0x80, B=0x01, SUB=1 -> S=0x7F, CO=1, OVF=1.
REQ-032 Scenario: start with 0x01+0x02, then start pulses with changed A/B at RUN bits 2 and 5 -> single done, S=0x03, no second operation.
REQ-033 Scenario: rst at RUN bit 4 -> next cycle busy=0, done=0, S=0, CO=0, OVF=0, and no done follows; a subsequent 0x7F+0x01 gives S=0x80, OVF=1.
REQ-034 Scenario: start held high continuously with A=0x0F, B=0xF0, CI=0 -> done every 10 cycles, each with S=0xFF, CO=0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one full adder walks the operands LSB first,
// then S/CO/OVF are latched together when the FSM enters DONE.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    input  logic             SUB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             OVF
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   opA_q, opA_d;
    logic [WIDTH-1:0]   opB_q, opB_d;
    logic               sub_q, sub_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   bitCnt_q, bitCnt_d;
    logic [WIDTH-1:0]   shadow_q, shadow_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               co_q, co_d;
    logic               ovf_q, ovf_d;

    logic aBit, bBit, sumBit, carryBit;

    // opB_q already holds ~B for subtraction; sub_q only qualifies the last-bit bookkeeping
    assign aBit     = opA_q[bitCnt_q];
    assign bBit     = opB_q[bitCnt_q];
    assign sumBit   = aBit ^ bBit ^ carry_q;
    assign carryBit = (aBit & bBit) | ((aBit ^ bBit) & carry_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            opA_q    <= '0;
            opB_q    <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            bitCnt_q <= '0;
            shadow_q <= '0;
            sum_q    <= '0;
            co_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opA_q    <= opA_d;
            opB_q    <= opB_d;
            sub_q    <= sub_d;
            carry_q  <= carry_d;
            bitCnt_q <= bitCnt_d;
            shadow_q <= shadow_d;
            sum_q    <= sum_d;
            co_q     <= co_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        sub_d    = sub_q;
        carry_d  = carry_q;
        bitCnt_d = bitCnt_q;
        shadow_d = shadow_q;
        sum_d    = sum_q;
        co_d     = co_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    opA_d    = A;
                    opB_d    = SUB ? ~B : B;
                    sub_d    = SUB;
                    carry_d  = SUB ? 1'b1 : CI;
                    bitCnt_d = '0;
                end
            end
            RUN: begin
                shadow_d[bitCnt_q] = sumBit;
                carry_d            = carryBit;
                if (bitCnt_q == CNT_W'(WIDTH - 1)) begin
                    // carry_q here is the carry into the MSB, needed for signed overflow
                    state_d = DONE;
                    sum_d   = shadow_d;
                    co_d    = carryBit;
                    ovf_d   = carry_q ^ carryBit;
                    sub_d   = 1'b0;
                end else begin
                    bitCnt_d = bitCnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE) & ~sub_q;
    assign S    = sum_q;
    assign CO   = co_q;
    assign OVF  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8: expected results are queued
// at acceptance and compared whenever done pulses.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [7:0] s;
        logic       co;
        logic       ovf;
    } result_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A, B;
    logic             CI, SUB;
    logic             busy, done, CO, OVF;
    logic [WIDTH-1:0] S;

    result_t sb[$];
    int      checkCount = 0;
    int      passCount  = 0;
    int      doneCount  = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .CI    (CI),
        .SUB   (SUB),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .CO    (CO),
        .OVF   (OVF)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Reference arithmetic done with a wide add, independent of the serial datapath
    function automatic result_t model(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sub);
        logic [7:0] bb;
        logic [8:0] wide;
        result_t    r;
        bb    = sub ? ~b : b;
        wide  = {1'b0, a} + {1'b0, bb} + {8'd0, (sub ? 1'b1 : ci)};
        r.s   = wide[7:0];
        r.co  = wide[8];
        r.ovf = (a[7] == bb[7]) && (wide[7] != a[7]);
        return r;
    endfunction

    // Every done pulse is matched against the oldest queued expectation
    always @(negedge clk) begin
        if (done) begin
            doneCount++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                result_t e;
                e = sb.pop_front();
                checkOutput("S", 32'(S), 32'(e.s));
                checkOutput("CO", 32'(CO), 32'(e.co));
                checkOutput("OVF", 32'(OVF), 32'(e.ovf));
            end
        end
    end

    // Called just after a falling edge with the DUT idle
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sub,
                                 output int latency, output int busyCycles);
        bit seen;
        A = a; B = b; CI = ci; SUB = sub; start = 1'b1;
        sb.push_back(model(a, b, ci, sub));
        @(posedge clk);
        #1;
        start = 1'b0;
        A = 8'($urandom); B = 8'($urandom); CI = 1'($urandom); SUB = 1'($urandom);
        latency = 0; busyCycles = 0; seen = 0;
        for (int c = 1; c <= 30 && !seen; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                latency = c;
            end else if (busy) begin
                busyCycles++;
            end
        end
        if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        checkOutput("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    int lat, bc, dc0;
    int doneAt[3];
    int nDone;

    initial begin
        rst = 1'b1; start = 1'b0; A = '0; B = '0; CI = 1'b0; SUB = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_S", 32'(S), 32'd0);
        checkOutput("rst_CO", 32'(CO), 32'd0);
        checkOutput("rst_OVF", 32'(OVF), 32'd0);

        applyStimulus(8'h5A, 8'h33, 1'b0, 1'b0, lat, bc);
        checkOutput("latency", 32'(lat), 32'(WIDTH + 1));
        checkOutput("busy_cycles", 32'(bc), 32'(WIDTH));
        checkOutput("S_hold", 32'(S), 32'h8D);

        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, lat, bc);
        applyStimulus(8'h00, 8'h00, 1'b1, 1'b0, lat, bc);
        applyStimulus(8'h10, 8'h20, 1'b1, 1'b1, lat, bc);
        applyStimulus(8'h80, 8'h01, 1'b0, 1'b1, lat, bc);
        applyStimulus(8'h7F, 8'h80, 1'b1, 1'b0, lat, bc);

        // start pulses during RUN must be ignored, not queued
        A = 8'h01; B = 8'h02; CI = 1'b0; SUB = 1'b0; start = 1'b1;
        sb.push_back(model(8'h01, 8'h02, 1'b0, 1'b0));
        dc0 = doneCount;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (c == 3 || c == 6) begin
                start = 1'b1; A = 8'hC3 + 8'(c); B = 8'h5C;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        checkOutput("ignored_start_dones", 32'(doneCount - dc0), 32'd1);
        checkOutput("ignored_start_S", 32'(S), 32'h03);

        // reset in the middle of RUN aborts the operation
        A = 8'h55; B = 8'h11; CI = 1'b0; SUB = 1'b0; start = 1'b1;
        dc0 = doneCount;
        @(posedge clk); #1 start = 1'b0;
        idleCycles(5);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_S", 32'(S), 32'd0);
        checkOutput("abort_CO", 32'(CO), 32'd0);
        checkOutput("abort_OVF", 32'(OVF), 32'd0);
        idleCycles(12);
        checkOutput("abort_no_done", 32'(doneCount - dc0), 32'd0);
        applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0, lat, bc);

        // reset beats start on the same edge
        A = 8'h11; B = 8'h22; start = 1'b1; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checkOutput("rst_over_start_busy", 32'(busy), 32'd0);
        idleCycles(12);

        // start held high: back-to-back operations
        for (int i = 0; i < 3; i++) sb.push_back(model(8'h0F, 8'hF0, 1'b0, 1'b0));
        A = 8'h0F; B = 8'hF0; CI = 1'b0; SUB = 1'b0; start = 1'b1;
        nDone = 0;
        for (int c = 1; c <= 60 && nDone < 3; c++) begin
            @(negedge clk);
            if (done) begin
                doneAt[nDone] = c;
                nDone++;
            end
        end
        start = 1'b0;
        checkOutput("b2b_done_count", 32'(nDone), 32'd3);
        if (nDone == 3) begin
            checkOutput("b2b_period1", 32'(doneAt[1] - doneAt[0]), 32'(WIDTH + 2));
            checkOutput("b2b_period2", 32'(doneAt[2] - doneAt[1]), 32'(WIDTH + 2));
        end
        idleCycles(14);

        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
